// File: rtl/nes_pad_pkg.sv
// Shared types and constants for the NES gamepad reader.
// Optional macro PAD_DEBOUNCE_EN is handled in nes_pad_reader.
package nes_pad_pkg;

  localparam int NUM_BUTTONS = 8;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    SETTLE,
    CLK_HIGH,
    CLK_LOW,
    DONE
  } pad_state_t;

endpackage

// File: rtl/nes_pad_sync.sv
// Two-flop synchronizer for the asynchronous pad data line.
// Both flops reset to 1 because an idle, released pad line reads high.
module nes_pad_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops give metastability time to resolve.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/nes_pad_reader.sv
// NES gamepad (CD4021) reader: latches the pad, clocks out 8 bits and
// publishes an active-high button byte with a one-cycle valid pulse.
// Optional macro PAD_DEBOUNCE_EN: publish only when two consecutive reads agree.
module nes_pad_reader
  import nes_pad_pkg::*;
#(
  parameter int LATCH_CYCLES = 4,
  parameter int HALF_CYCLES  = 3,
  parameter int POLL_CYCLES  = 0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   poll_req_i,
  input  logic                   pad_data_i,
  output logic                   pad_latch_o,
  output logic                   pad_clk_o,
  output logic [NUM_BUTTONS-1:0] buttons_o,
  output logic                   valid_o,
  output logic                   busy_o
);

  localparam int TMAX = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
  localparam int TW   = $clog2(TMAX) + 1;
  localparam logic [TW-1:0] LATCH_LOAD = TW'(LATCH_CYCLES - 1);
  localparam logic [TW-1:0] HALF_LOAD  = TW'(HALF_CYCLES - 1);

  pad_state_t             state_q, state_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [2:0]             bit_q, bit_d;
  logic [NUM_BUTTONS-1:0] shift_q, shift_d;
  logic [NUM_BUTTONS-1:0] buttons_q, buttons_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;
  logic                   latch_q, latch_d;
  logic                   pclk_q, pclk_d;
`ifdef PAD_DEBOUNCE_EN
  logic [NUM_BUTTONS-1:0] prev_raw_q, prev_raw_d;
`endif

  logic pad_sync;
  logic auto_fire;

  nes_pad_sync u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (pad_data_i),
    .q_o   (pad_sync)
  );

  generate
    if (POLL_CYCLES != 0) begin : g_auto
      localparam int PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
      logic [PW-1:0] poll_q, poll_d;

      // Free-running down-counter; reloads on expiry whatever the FSM is doing.
      always_comb begin
        poll_d = poll_q - PW'(1);
        if (poll_q == '0) begin
          poll_d = PW'(POLL_CYCLES - 1);
        end
      end

      // Auto-poll period register.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          poll_q <= '0;
        end else begin
          poll_q <= poll_d;
        end
      end

      assign auto_fire = (poll_q == '0);
    end else begin : g_noauto
      assign auto_fire = 1'b0;
    end
  endgenerate

  // Next-state logic: phase sequencing, bit sampling and result publication.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    buttons_d = buttons_q;
    valid_d   = 1'b0;
`ifdef PAD_DEBOUNCE_EN
    prev_raw_d = prev_raw_q;
`endif

    case (state_q)
      IDLE: begin
        if (poll_req_i || auto_fire) begin
          state_d = LATCH;
          timer_d = LATCH_LOAD;
          bit_d   = 3'd0;
          shift_d = '1;
        end
      end

      LATCH: begin
        if (timer_q == '0) begin
          state_d = SETTLE;
          timer_d = HALF_LOAD;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end

      SETTLE: begin
        if (timer_q == '0) begin
          shift_d[0] = pad_sync;
          state_d    = CLK_HIGH;
          timer_d    = HALF_LOAD;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end

      CLK_HIGH: begin
        if (timer_q == '0) begin
          state_d = CLK_LOW;
          timer_d = HALF_LOAD;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end

      CLK_LOW: begin
        if (timer_q == '0) begin
          bit_d          = bit_q + 3'd1;
          shift_d[bit_d] = pad_sync;
          timer_d        = HALF_LOAD;
          state_d        = (bit_d == 3'd7) ? DONE : CLK_HIGH;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end

      DONE: begin
`ifdef PAD_DEBOUNCE_EN
        if (shift_q == prev_raw_q) begin
          buttons_d = ~shift_q;
          valid_d   = 1'b1;
        end
        prev_raw_d = shift_q;
`else
        buttons_d = ~shift_q;
        valid_d   = 1'b1;
`endif
        state_d = IDLE;
        timer_d = '0;
        bit_d   = 3'd0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    latch_d = (state_d == LATCH);
    pclk_d  = (state_d == CLK_HIGH);
    busy_d  = (state_d != IDLE);
  end

  // State and output registers; the pad strobes come straight from flops.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      bit_q     <= 3'd0;
      shift_q   <= '1;
      buttons_q <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      latch_q   <= 1'b0;
      pclk_q    <= 1'b0;
`ifdef PAD_DEBOUNCE_EN
      prev_raw_q <= '1;
`endif
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      buttons_q <= buttons_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      latch_q   <= latch_d;
      pclk_q    <= pclk_d;
`ifdef PAD_DEBOUNCE_EN
      prev_raw_q <= prev_raw_d;
`endif
    end
  end

  assign pad_latch_o = latch_q;
  assign pad_clk_o   = pclk_q;
  assign buttons_o   = buttons_q;
  assign valid_o     = valid_q;
  assign busy_o      = busy_q;

endmodule
